// File: rtl/comp_conv_sched.sv
// rtl/comp_conv_sched.sv - round-robin shared sign-magnitude to two's-complement converter
// Optional macro COMP_CONV_NEGZERO_FIX_EN: negative zero maps to 0 and adds sticky negzero_seen.
module comp_conv_sched #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*DW-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      conv_cnt
`ifdef COMP_CONV_NEGZERO_FIX_EN
    ,
    output logic                  negzero_seen
`endif
);

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   hold_id_q, hold_id_d;
    logic [DW-1:0]     hold_data_q, hold_data_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  conv_cnt_q, conv_cnt_d;
`ifdef COMP_CONV_NEGZERO_FIX_EN
    logic              negzero_q, negzero_d;
`endif

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [DW-1:0]     grant_data;
    logic [DW-2:0]     mag_neg;

    // Walk offsets from farthest to nearest so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
        grant_data = req_data[int'(grant_idx)*DW +: DW];
    end

    // Carry out of the +1 is dropped, so negative zero wraps to magnitude 0.
    assign mag_neg = ~hold_data_q[DW-2:0] + {{(DW-2){1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        hold_id_d   = hold_id_q;
        hold_data_d = hold_data_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        conv_cnt_d  = conv_cnt_q;
        req_ready   = '0;
`ifdef COMP_CONV_NEGZERO_FIX_EN
        negzero_d   = negzero_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    hold_data_d = grant_data;
                    hold_id_d   = grant_idx;
                    rr_ptr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d     = CONV;
                end
            end
            CONV: begin
                if (hold_data_q[DW-1]) begin
                    out_data_d = {1'b1, mag_neg};
`ifdef COMP_CONV_NEGZERO_FIX_EN
                    if (hold_data_q[DW-2:0] == '0) begin
                        out_data_d = '0;
                        negzero_d  = 1'b1;
                    end
`endif
                end else begin
                    out_data_d = hold_data_q;
                end
                out_id_d    = hold_id_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    conv_cnt_d  = conv_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            hold_id_q   <= '0;
            hold_data_q <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
            conv_cnt_q  <= '0;
`ifdef COMP_CONV_NEGZERO_FIX_EN
            negzero_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_id_q   <= hold_id_d;
            hold_data_q <= hold_data_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
            conv_cnt_q  <= conv_cnt_d;
`ifdef COMP_CONV_NEGZERO_FIX_EN
            negzero_q   <= negzero_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q != IDLE);
    assign conv_cnt  = conv_cnt_q;
`ifdef COMP_CONV_NEGZERO_FIX_EN
    assign negzero_seen = negzero_q;
`endif

endmodule

// File: tb/tb_comp_conv_sched.sv
// tb/tb_comp_conv_sched.sv - directed self-checking bench for comp_conv_sched
module tb_comp_conv_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        busy;
    logic [15:0] conv_cnt;
`ifdef COMP_CONV_NEGZERO_FIX_EN
    logic        negzero_seen;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    comp_conv_sched #(.N_REQ(4), .DW(8), .ID_W(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy),
        .conv_cnt  (conv_cnt)
`ifdef COMP_CONV_NEGZERO_FIX_EN
        ,
        .negzero_seen (negzero_seen)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_single(input int id, input logic [7:0] word,
                              output logic [7:0] d, output logic [1:0] oid, output logic ok);
        int n;
        ok = 1'b1;
        d = '0;
        oid = '0;
        req_data = '0;
        req_data[id*8 +: 8] = word;
        req_valid = 4'(1 << id);
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) ok = 1'b0;
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) ok = 1'b0;
        d = out_data;
        oid = out_id;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got %h want 00", out_data); end
        n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL rst_out_id got %0d want 0", out_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_checks++; if (conv_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_conv_cnt got %0d want 0", conv_cnt); end
`ifdef COMP_CONV_NEGZERO_FIX_EN
        n_checks++; if (negzero_seen !== 1'b0) begin n_fail++; $display("FAIL rst_negzero got %b want 0", negzero_seen); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        req_data = 32'h0000_0005;
        req_valid = 4'b0001;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t1_grant got %b want 0001", req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL t1_conv_ready got %b want 0000", req_ready); end
        n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_conv got busy=%b valid=%b want 1 0", busy, out_valid); end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 8'h05 || out_id !== 2'd0) begin n_fail++; $display("FAIL t1_result got %h/%0d want 05/0", out_data, out_id); end
        n_checks++; if (conv_cnt !== 16'd0) begin n_fail++; $display("FAIL t1_cnt_pre got %0d want 0", conv_cnt); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || conv_cnt !== 16'd1) begin n_fail++; $display("FAIL t1_done got valid=%b cnt=%0d want 0 1", out_valid, conv_cnt); end
    endtask

    task automatic test_convert;
        logic [7:0] d;
        logic [1:0] oid;
        logic ok;
        logic [7:0] words [3];
        logic [7:0] exp_d [3];
        words = '{8'h85, 8'hFF, 8'h7F};
        exp_d = '{8'hFB, 8'h81, 8'h7F};
        for (int i = 0; i < 3; i++) begin
            run_single(2, words[i], d, oid, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL t2_timeout word %h", words[i]); end
            n_checks++; if (d !== exp_d[i] || oid !== 2'd2) begin n_fail++; $display("FAIL t2_conv word %h got %h/%0d want %h/2", words[i], d, oid, exp_d[i]); end
        end
    endtask

    task automatic test_round_robin;
        int grants [6];
        int gcyc [6];
        int outs [6];
        int ng, no, cyc;
        apply_reset();
        req_data = 32'h04_03_02_01;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        ng = 0;
        no = 0;
        cyc = 0;
        while ((ng < 6 || no < 6) && cyc < 60) begin
            if (req_ready != 4'b0000 && ng < 6) begin
                grants[ng] = -1;
                for (int b = 0; b < 4; b++) if (req_ready[b]) grants[ng] = b;
                gcyc[ng] = cyc;
                ng++;
            end
            if (out_valid === 1'b1 && no < 6) begin
                outs[no] = int'(out_id);
                no++;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        out_ready = 1'b0;
        n_checks++; if (ng != 6 || no != 6) begin n_fail++; $display("FAIL t3_timeout got %0d grants %0d outs want 6 6", ng, no); end
        for (int i = 0; i < ng; i++) begin
            n_checks++; if (grants[i] != i % 4) begin n_fail++; $display("FAIL t3_grant[%0d] got %0d want %0d", i, grants[i], i % 4); end
            if (i > 0) begin
                n_checks++; if (gcyc[i] - gcyc[i-1] != 3) begin n_fail++; $display("FAIL t3_spacing[%0d] got %0d want 3", i, gcyc[i] - gcyc[i-1]); end
            end
        end
        for (int i = 0; i < no; i++) begin
            n_checks++; if (outs[i] != i % 4) begin n_fail++; $display("FAIL t3_out_id[%0d] got %0d want %0d", i, outs[i], i % 4); end
        end
    endtask

    task automatic test_backpressure;
        int n;
        apply_reset();
        req_data = 32'h0000_8300;
        req_valid = 4'b0010;
        #1;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 4'b1111;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (n >= 20) begin n_fail++; $display("FAIL t4_timeout out_valid never rose"); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hFD || out_id !== 2'd1 || busy !== 1'b1 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL t4_hold cyc %0d got v=%b d=%h id=%0d busy=%b rdy=%b want 1 fd 1 1 0000",
                         i, out_valid, out_data, out_id, busy, req_ready);
            end
            @(negedge clk);
        end
        req_valid = '0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || conv_cnt !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL t4_done got v=%b cnt=%0d busy=%b want 0 1 0", out_valid, conv_cnt, busy); end
    endtask

    task automatic test_negzero;
        logic [7:0] d;
        logic [1:0] oid;
        logic ok;
        logic [7:0] exp_d;
        apply_reset();
`ifdef COMP_CONV_NEGZERO_FIX_EN
        exp_d = 8'h00;
`else
        exp_d = 8'h80;
`endif
        run_single(0, 8'h80, d, oid, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL t5_timeout"); end
        n_checks++; if (d !== exp_d || oid !== 2'd0) begin n_fail++; $display("FAIL t5_negzero got %h/%0d want %h/0", d, oid, exp_d); end
`ifdef COMP_CONV_NEGZERO_FIX_EN
        n_checks++; if (negzero_seen !== 1'b1) begin n_fail++; $display("FAIL t5_sticky got %b want 1", negzero_seen); end
`endif
    endtask

    task automatic test_reset_mid;
        int n;
        req_data = 32'h1200_0000;
        req_valid = 4'b1000;
        #1;
        n = 0;
        while (req_ready[3] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (out_valid !== 1'b1 || conv_cnt !== 16'd1) begin n_fail++; $display("FAIL t6_pre got v=%b cnt=%0d want 1 1", out_valid, conv_cnt); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || conv_cnt !== 16'd0) begin n_fail++; $display("FAIL t6_async got v=%b cnt=%0d want 0 0", out_valid, conv_cnt); end
        n_checks++; if (busy !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL t6_state got busy=%b d=%h want 0 00", busy, out_data); end
        req_data = 32'h44_33_22_11;
        req_valid = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t6_first_grant got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t6_busy got %b want 1", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_convert();
        test_round_robin();
        test_backpressure();
        test_negzero();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
